// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - 4-beat 64-bit cache-line burst memory responder
module burst_mem_responder #(
   parameter int DEPTH_LINES  = 64,
   parameter int READ_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bfp_addr,
   input  logic        bfp_read,
   input  logic        bfp_write,
   input  logic [63:0] bfp_wdata,
   output logic        bfp_ready,
   output logic [63:0] bfp_rdata,
   output logic [31:0] bfp_raddr,
   output logic        bfp_rvalid,
   output logic        err
);

   localparam int         IDX_W    = $clog2(DEPTH_LINES);
   localparam int         MEM_W    = IDX_W + 2;
   localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_WAIT,
      ST_RD_BURST
   } state_t;

   state_t            state_q, state_d;
   logic [26:0]       line_q, line_d;
   logic [1:0]        beat_q, beat_d;
   logic [3:0]        lat_q, lat_d;
   logic              ready_d, rvalid_d, err_d;
   logic [63:0]       rdata_d;
   logic [31:0]       raddr_d;

   logic              mem_we;
   logic [MEM_W-1:0]  mem_waddr;
   logic [63:0]       mem_wdata;
   logic [MEM_W-1:0]  rd_ptr;
   logic [63:0]       mem [DEPTH_LINES*4];

   logic              accept_write;
   logic              accept_read;
   logic              addr_match;

   // Byte offset within a line never selects anything: beats are sequenced internally.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^bfp_addr[4:0];

   // A simultaneous read and write in IDLE is taken as the write.
   assign accept_write = bfp_ready & bfp_write;
   assign accept_read  = bfp_ready & bfp_read & ~bfp_write;
   assign addr_match   = (bfp_addr[31:5] == line_q);

   // Next-state, next-output and memory-port decode.
   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      beat_d    = beat_q;
      lat_d     = lat_q;
      ready_d   = bfp_ready;
      rvalid_d  = 1'b0;
      err_d     = err;
      rdata_d   = bfp_rdata;
      raddr_d   = bfp_raddr;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = bfp_wdata;
      rd_ptr    = {line_q[IDX_W-1:0], 2'd0};

      case (state_q)
         ST_IDLE: begin
            // ready comes up one edge after reset release, then requests are taken
            ready_d = 1'b1;
            if (accept_write) begin
               mem_we    = 1'b1;
               mem_waddr = {bfp_addr[5 +: IDX_W], 2'd0};
               line_d    = bfp_addr[31:5];
               beat_d    = 2'd1;
               state_d   = ST_WRITE;
               if (bfp_read) begin
                  err_d = 1'b1;
               end
            end else if (accept_read) begin
               line_d  = bfp_addr[31:5];
               raddr_d = {bfp_addr[31:5], 5'b0};
               lat_d   = LAT_INIT;
               ready_d = 1'b0;
               state_d = ST_RD_WAIT;
            end
         end

         ST_WRITE: begin
            ready_d = 1'b1;
            if (bfp_ready && bfp_read) begin
               err_d = 1'b1;
            end
            if (bfp_ready && bfp_write) begin
               // beats always land in the line latched on beat 0
               mem_we    = 1'b1;
               mem_waddr = {line_q[IDX_W-1:0], beat_q};
               if (!addr_match) begin
                  err_d = 1'b1;
               end
               if (beat_q == 2'd3) begin
                  beat_d  = 2'd0;
                  state_d = ST_IDLE;
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end

         ST_RD_WAIT: begin
            ready_d = 1'b0;
            if (lat_q == 4'd0) begin
               // beat 0 is registered on the edge that enters the burst
               rd_ptr   = {line_q[IDX_W-1:0], 2'd0};
               rdata_d  = mem[rd_ptr];
               rvalid_d = 1'b1;
               beat_d   = 2'd0;
               state_d  = ST_RD_BURST;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end

         ST_RD_BURST: begin
            ready_d = 1'b0;
            if (beat_q == 2'd3) begin
               // last beat has been presented; drop rvalid and reopen the port together
               beat_d  = 2'd0;
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               rd_ptr   = {line_q[IDX_W-1:0], beat_q + 2'd1};
               rdata_d  = mem[rd_ptr];
               rvalid_d = 1'b1;
               beat_d   = beat_q + 2'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; memory array is deliberately left out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         line_q     <= '0;
         beat_q     <= '0;
         lat_q      <= '0;
         bfp_ready  <= 1'b0;
         bfp_rvalid <= 1'b0;
         bfp_rdata  <= '0;
         bfp_raddr  <= '0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         beat_q     <= beat_d;
         lat_q      <= lat_d;
         bfp_ready  <= ready_d;
         bfp_rvalid <= rvalid_d;
         bfp_rdata  <= rdata_d;
         bfp_raddr  <= raddr_d;
         err        <= err_d;
      end
   end

   // Line storage, one 64-bit word per beat.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - directed self-checking bench for burst_mem_responder
module tb_burst_mem_responder;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bfp_addr;
   logic        bfp_read;
   logic        bfp_write;
   logic [63:0] bfp_wdata;
   logic        bfp_ready;
   logic [63:0] bfp_rdata;
   logic [31:0] bfp_raddr;
   logic        bfp_rvalid;
   logic        err;

   int total = 0;
   int bad   = 0;

   burst_mem_responder #(.DEPTH_LINES(64), .READ_LATENCY(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .bfp_addr  (bfp_addr),
      .bfp_read  (bfp_read),
      .bfp_write (bfp_write),
      .bfp_wdata (bfp_wdata),
      .bfp_ready (bfp_ready),
      .bfp_rdata (bfp_rdata),
      .bfp_raddr (bfp_raddr),
      .bfp_rvalid(bfp_rvalid),
      .err       (err)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_beat(input logic [31:0] a, input logic [63:0] d, input logic rd);
      bfp_addr  = a;
      bfp_wdata = d;
      bfp_write = 1'b1;
      bfp_read  = rd;
      tick();
      bfp_write = 1'b0;
      bfp_read  = 1'b0;
   endtask

   task automatic write_line(input logic [31:0] a, input logic [255:0] line);
      for (int k = 0; k < 4; k++) begin
         write_beat(a, line[64*k +: 64], 1'b0);
      end
   endtask

   task automatic wait_rvalid(input string tag);
      int n;
      n = 0;
      while (!bfp_rvalid && n < 40) begin
         tick();
         n++;
      end
      check($sformatf("%s_latency", tag), 64'(n), 64'(L));
   endtask

   task automatic burst_check(input string tag, input logic [31:0] a, input logic [255:0] line);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_rvalid%0d", tag, k), 64'(bfp_rvalid), 64'd1);
         check($sformatf("%s_rdata%0d", tag, k), bfp_rdata, line[64*k +: 64]);
         check($sformatf("%s_raddr%0d", tag, k), 64'(bfp_raddr), 64'({a[31:5], 5'b0}));
         tick();
      end
      check($sformatf("%s_end_rvalid", tag), 64'(bfp_rvalid), 64'd0);
      check($sformatf("%s_end_ready", tag), 64'(bfp_ready), 64'd1);
   endtask

   task automatic read_check(input string tag, input logic [31:0] a, input logic [255:0] line);
      check($sformatf("%s_ready_pre", tag), 64'(bfp_ready), 64'd1);
      bfp_addr = a;
      bfp_read = 1'b1;
      tick();
      bfp_read = 1'b0;
      check($sformatf("%s_ready_wait", tag), 64'(bfp_ready), 64'd0);
      wait_rvalid(tag);
      burst_check(tag, a, line);
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   logic [255:0] line_a, line_b, line_c, line_d, line_e, line_f;
   int           seen;

   initial begin
      line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      line_b = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
      line_c = {64'hC000_0000_0000_0403, 64'hC000_0000_0000_0402,
                64'hC000_0000_0000_0401, 64'hC000_0000_0000_0400};
      line_d = {64'hD000_0000_0000_0603, 64'hD000_0000_0000_0602,
                64'hD000_0000_0000_0601, 64'hD000_0000_0000_0600};
      line_e = {64'hE0E0_E0E0_0000_0803, 64'hE0E0_E0E0_0000_0802,
                64'hE0E0_E0E0_0000_0801, 64'hE0E0_E0E0_0000_0800};
      line_f = {64'hF0F0_0000_3140_0003, 64'hF0F0_0000_3140_0002,
                64'hF0F0_0000_3140_0001, 64'hF0F0_0000_3140_0000};

      rst       = 1'b1;
      bfp_addr  = '0;
      bfp_read  = 1'b0;
      bfp_write = 1'b0;
      bfp_wdata = '0;

      // reset values
      #2 rst = 1'b0;
      #1;
      check("rst_ready", 64'(bfp_ready), 64'd0);
      check("rst_rvalid", 64'(bfp_rvalid), 64'd0);
      check("rst_rdata", bfp_rdata, 64'd0);
      check("rst_raddr", 64'(bfp_raddr), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      check("rel_ready_before_edge", 64'(bfp_ready), 64'd0);
      tick();
      check("rel_ready_after_edge", 64'(bfp_ready), 64'd1);

      // basic write then read
      write_line(32'h0000_1020, line_a);
      check("t1_ready", 64'(bfp_ready), 64'd1);
      read_check("t1", 32'h0000_1020, line_a);
      check("t1_err", 64'(err), 64'd0);

      // write with idle gap between beats 1 and 2
      write_beat(32'h0000_2080, line_b[63:0], 1'b0);
      write_beat(32'h0000_2080, line_b[127:64], 1'b0);
      tick();
      check("t2_gap1_ready", 64'(bfp_ready), 64'd1);
      tick();
      check("t2_gap2_ready", 64'(bfp_ready), 64'd1);
      write_beat(32'h0000_2080, line_b[191:128], 1'b0);
      check("t2_b2_ready", 64'(bfp_ready), 64'd1);
      write_beat(32'h0000_2080, line_b[255:192], 1'b0);
      check("t2_err", 64'(err), 64'd0);
      read_check("t2", 32'h0000_2080, line_b);

      // back-to-back reads with read held high
      write_line(32'h0000_0040, line_c);
      write_line(32'h0000_0060, line_d);
      bfp_addr = 32'h0000_0040;
      bfp_read = 1'b1;
      tick();
      bfp_addr = 32'h0000_0060;
      wait_rvalid("t3a");
      burst_check("t3a", 32'h0000_0040, line_c);
      check("t3_raddr_hold", 64'(bfp_raddr), 64'h40);
      tick();
      bfp_read = 1'b0;
      check("t3b_ready_wait", 64'(bfp_ready), 64'd0);
      check("t3b_raddr_acc", 64'(bfp_raddr), 64'h60);
      wait_rvalid("t3b");
      burst_check("t3b", 32'h0000_0060, line_d);

      // index aliasing: 0x800 maps onto line index 0
      write_line(32'h0000_0800, line_e);
      read_check("t4", 32'h0000_0000, line_e);

      // address change on beat 2 lands at the latched line and flags err
      write_beat(32'h0000_3140, line_f[63:0], 1'b0);
      write_beat(32'h0000_3140, line_f[127:64], 1'b0);
      check("t5a_err_clean", 64'(err), 64'd0);
      write_beat(32'h0000_3160, line_f[191:128], 1'b0);
      check("t5a_err_set", 64'(err), 64'd1);
      write_beat(32'h0000_3140, line_f[255:192], 1'b0);
      read_check("t5a", 32'h0000_3140, line_f);

      // read&write together in IDLE is a write with err
      do_reset();
      check("t5b_err_cleared", 64'(err), 64'd0);
      write_beat(32'h0000_0800, line_a[63:0], 1'b1);
      check("t5b_err_set", 64'(err), 64'd1);
      check("t5b_ready", 64'(bfp_ready), 64'd1);
      write_beat(32'h0000_0800, line_a[127:64], 1'b0);
      write_beat(32'h0000_0800, line_a[191:128], 1'b0);
      write_beat(32'h0000_0800, line_a[255:192], 1'b0);
      read_check("t5b", 32'h0000_0000, line_a);
      check("t5b_err_sticky", 64'(err), 64'd1);

      // reset during burst beat 1
      bfp_addr = 32'h0000_1020;
      bfp_read = 1'b1;
      tick();
      bfp_read = 1'b0;
      wait_rvalid("t6");
      check("t6_beat0", bfp_rdata, line_a[63:0]);
      tick();
      check("t6_beat1_valid", 64'(bfp_rvalid), 64'd1);
      check("t6_beat1", bfp_rdata, line_a[127:64]);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_rvalid", 64'(bfp_rvalid), 64'd0);
      check("t6_rst_ready", 64'(bfp_ready), 64'd0);
      check("t6_rst_err", 64'(err), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("t6_rel_ready", 64'(bfp_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (bfp_rvalid) seen++;
         tick();
      end
      check("t6_no_replay", 64'(seen), 64'd0);
      read_check("t6_after", 32'h0000_1020, line_a);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
